// File: rtl/bus_terminal_fifo.sv
// Per-terminal TX/RX packet queues between a device port and the shared bus arbiter.
// Sticky error flags and a saturating drop counter support scoreboarding.
module bus_terminal_fifo #(
  parameter int pckg_sz = 16,
  parameter int depth   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tx_valid,
  input  logic [pckg_sz-1:0]         tx_data,
  output logic                       tx_ready,
  output logic                       pndng,
  output logic [pckg_sz-1:0]         D_pop,
  input  logic                       pop,
  input  logic                       push,
  input  logic [pckg_sz-1:0]         D_push,
  output logic                       rx_valid,
  output logic [pckg_sz-1:0]         rx_data,
  input  logic                       rx_ready,
  output logic [$clog2(depth):0]     tx_count,
  output logic [$clog2(depth):0]     rx_count,
  output logic                       pop_err,
  output logic                       rx_ovf,
  output logic [7:0]                 drop_cnt,
  input  logic                       clr_err
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);

  logic [pckg_sz-1:0] tx_mem_q [depth];
  logic [pckg_sz-1:0] tx_mem_d [depth];
  logic [pckg_sz-1:0] rx_mem_q [depth];
  logic [pckg_sz-1:0] rx_mem_d [depth];
  logic [AW-1:0]      tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [AW-1:0]      rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [CW-1:0]      tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic               pop_err_q, pop_err_d, rx_ovf_q, rx_ovf_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;
  logic               tx_wr, tx_rd, rx_wr, rx_rd, rx_drop;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [CW-1:0] next_cnt(input logic [CW-1:0] c, input logic wr,
                                             input logic rd);
    logic [CW-1:0] r;
    r = c;
    if (wr && !rd) r = c + CW'(1);
    else if (rd && !wr) r = c - CW'(1);
    return r;
  endfunction

  // Outputs come only from registered state; no input reaches an output combinationally.
  assign tx_ready = (tx_cnt_q < DEPTH_C);
  assign pndng    = (tx_cnt_q != '0);
  assign D_pop    = tx_mem_q[tx_rd_ptr_q];
  assign rx_valid = (rx_cnt_q != '0);
  assign rx_data  = rx_mem_q[rx_rd_ptr_q];
  assign tx_count = tx_cnt_q;
  assign rx_count = rx_cnt_q;
  assign pop_err  = pop_err_q;
  assign rx_ovf   = rx_ovf_q;
  assign drop_cnt = drop_cnt_q;

  // A full RX queue still accepts a push when the device drains the head in the same cycle.
  assign tx_wr   = tx_valid & tx_ready;
  assign tx_rd   = pop & pndng;
  assign rx_rd   = rx_valid & rx_ready;
  assign rx_wr   = push & ((rx_cnt_q != DEPTH_C) | rx_rd);
  assign rx_drop = push & ~rx_wr;

  always_comb begin
    tx_mem_d    = tx_mem_q;
    rx_mem_d    = rx_mem_q;
    tx_wr_ptr_d = tx_wr_ptr_q + AW'(tx_wr);
    tx_rd_ptr_d = tx_rd_ptr_q + AW'(tx_rd);
    rx_wr_ptr_d = rx_wr_ptr_q + AW'(rx_wr);
    rx_rd_ptr_d = rx_rd_ptr_q + AW'(rx_rd);
    tx_cnt_d    = next_cnt(tx_cnt_q, tx_wr, tx_rd);
    rx_cnt_d    = next_cnt(rx_cnt_q, rx_wr, rx_rd);
    if (tx_wr) tx_mem_d[tx_wr_ptr_q] = tx_data;
    if (rx_wr) rx_mem_d[rx_wr_ptr_q] = D_push;
    // Clear wins over an error arriving in the same cycle.
    if (clr_err) begin
      pop_err_d  = 1'b0;
      rx_ovf_d   = 1'b0;
      drop_cnt_d = 8'd0;
    end else begin
      pop_err_d  = pop_err_q | (pop & ~pndng);
      rx_ovf_d   = rx_ovf_q | rx_drop;
      drop_cnt_d = rx_drop ? sat_inc8(drop_cnt_q) : drop_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < depth; i++) begin
        tx_mem_q[i] <= '0;
        rx_mem_q[i] <= '0;
      end
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      pop_err_q   <= 1'b0;
      rx_ovf_q    <= 1'b0;
      drop_cnt_q  <= 8'd0;
    end else begin
      tx_mem_q    <= tx_mem_d;
      rx_mem_q    <= rx_mem_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      pop_err_q   <= pop_err_d;
      rx_ovf_q    <= rx_ovf_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_terminal_fifo.sv
// Directed self-checking bench for bus_terminal_fifo (pckg_sz=16, depth=8).
module tb_bus_terminal_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_valid, pop, push, rx_ready, clr_err;
  logic [15:0] tx_data, D_push;
  logic        tx_ready, pndng, rx_valid, pop_err, rx_ovf;
  logic [15:0] D_pop, rx_data;
  logic [3:0]  tx_count, rx_count;
  logic [7:0]  drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  bus_terminal_fifo #(.pckg_sz(16), .depth(8)) dut (
    .clk(clk), .reset(reset),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_count(tx_count), .rx_count(rx_count),
    .pop_err(pop_err), .rx_ovf(rx_ovf), .drop_cnt(drop_cnt),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle 1 ns past it, so sampling and driving stay off the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; tx_valid = 0; pop = 0; push = 0; rx_ready = 0; clr_err = 0;
    tx_data = '0; D_push = '0;
    tick(); tick();
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_pndng", pndng, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_count", tx_count, 0);
    chk("rst_D_pop", D_pop, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_pop_err", pop_err, 0);
    reset = 1'b1;
    tick();

    // TX ordering and latency
    tx_valid = 1; tx_data = 16'h0A01; tick();
    chk("tx_first_pndng", pndng, 1);
    chk("tx_first_D_pop", D_pop, 16'h0A01);
    tx_data = 16'h0B02; tick();
    tx_data = 16'h0C03; tick();
    tx_valid = 0;
    chk("tx_count3", tx_count, 3);
    pop = 1;
    chk("tx_pop0", D_pop, 16'h0A01); tick();
    chk("tx_pop1", D_pop, 16'h0B02); tick();
    chk("tx_pop2", D_pop, 16'h0C03); tick();
    pop = 0;
    chk("tx_empty_pndng", pndng, 0);
    chk("tx_empty_count", tx_count, 0);

    // TX full, write rejected under simultaneous pop
    tx_valid = 1;
    for (int i = 0; i < 8; i++) begin
      tx_data = 16'h1000 + 16'(i); tick();
    end
    chk("tx_full_ready", tx_ready, 0);
    chk("tx_full_count", tx_count, 8);
    tx_data = 16'h1008; pop = 1; tick();
    chk("tx_full_pop_count", tx_count, 7);
    pop = 0; tick();
    tx_valid = 0;
    chk("tx_refill_count", tx_count, 8);
    pop = 1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("tx_drain%0d", i), D_pop, 16'h1000 + 16'(i));
      tick();
    end
    pop = 0;
    chk("tx_drained_pndng", pndng, 0);

    // Pop on empty; clear priority
    pop = 1; tick(); pop = 0;
    chk("pop_err_set", pop_err, 1);
    chk("pop_err_count", tx_count, 0);
    tx_valid = 1; tx_data = 16'h2222; tick(); tx_valid = 0;
    chk("pop_err_noptr", D_pop, 16'h2222);
    pop = 1; tick(); pop = 0;
    clr_err = 1; tick(); clr_err = 0;
    chk("pop_err_clr", pop_err, 0);
    pop = 1; clr_err = 1; tick(); pop = 0; clr_err = 0;
    chk("clr_priority", pop_err, 0);

    // RX overflow and drop count
    push = 1;
    for (int i = 0; i < 10; i++) begin
      D_push = 16'h0100 + 16'(i); tick();
    end
    push = 0;
    chk("rx_full_count", rx_count, 8);
    chk("rx_ovf_set", rx_ovf, 1);
    chk("rx_drop2", drop_cnt, 2);
    chk("rx_head", rx_data, 16'h0100);
    push = 1; D_push = 16'h0FFF; rx_ready = 1; tick(); push = 0;
    chk("rx_swap_count", rx_count, 8);
    chk("rx_swap_drop", drop_cnt, 2);
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("rx_drain%0d", i), rx_data, 16'h0100 + 16'(i));
      tick();
    end
    chk("rx_drain_last", rx_data, 16'h0FFF);
    tick();
    rx_ready = 0;
    chk("rx_empty", rx_valid, 0);
    clr_err = 1; tick(); clr_err = 0;
    chk("rx_ovf_clr", rx_ovf, 0);
    chk("drop_clr", drop_cnt, 0);

    // Asynchronous reset between edges with both FIFOs half full
    tx_valid = 1; push = 1;
    for (int i = 0; i < 4; i++) begin
      tx_data = 16'h3000 + 16'(i); D_push = 16'h4000 + 16'(i); tick();
    end
    tx_valid = 0; push = 0;
    chk("mid_tx_count", tx_count, 4);
    chk("mid_rx_count", rx_count, 4);
    #2 reset = 1'b0; #1;
    chk("arst_pndng", pndng, 0);
    chk("arst_rx_valid", rx_valid, 0);
    chk("arst_tx_ready", tx_ready, 1);
    chk("arst_D_pop", D_pop, 0);
    chk("arst_rx_data", rx_data, 0);
    chk("arst_rx_count", rx_count, 0);
    tick(); reset = 1'b1; tick();
    chk("post_rst_pndng", pndng, 0);
    chk("post_rst_rx_valid", rx_valid, 0);

    // Drop counter saturation
    push = 1; D_push = 16'h5555;
    for (int i = 0; i < 8 + 260; i++) tick();
    push = 0;
    chk("drop_sat", drop_cnt, 255);
    chk("drop_sat_count", rx_count, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
